m_wb_arbiter: RTL

- Writeback arbiter that drives the single write port of the integer register file.
- Merges two result sources:
  - Channel A: the in-order pipeline's single-cycle results. No backpressure; always has priority.
  - Channel B: the multi-cycle unit (load/store, mul/div), with valid/ready handshake. Results are buffered in a DEPTH-entry FIFO.
- Sits between execute/memory and the register file. Also exports a pending-write mask for hazard detection and a stall request against starvation of channel B.

---
 rtl/m_wb_arbiter_if.sv | 29 ++
 rtl/m_wb_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/m_wb_arbiter_if.sv
// rtl/m_wb_arbiter_if.sv - writeback arbiter channel and register-file port bundle
interface m_wb_arbiter_if;
    logic        w_a_valid;
    logic [4:0]  w_a_wa;
    logic [31:0] w_a_wd;
    logic        w_b_valid;
    logic        w_b_ready;
    logic [4:0]  w_b_wa;
    logic [31:0] w_b_wd;
    logic        w_we;
    logic [4:0]  w_wa;
    logic [31:0] w_wd;
    logic [31:0] w_pend_mask;
    logic        w_stall_req;

    modport master (
        output w_a_valid, w_a_wa, w_a_wd,
        output w_b_valid, w_b_wa, w_b_wd,
        input  w_b_ready,
        input  w_we, w_wa, w_wd, w_pend_mask, w_stall_req
    );

    modport slave (
        input  w_a_valid, w_a_wa, w_a_wd,
        input  w_b_valid, w_b_wa, w_b_wd,
        output w_b_ready,
        output w_we, w_wa, w_wd, w_pend_mask, w_stall_req
    );
endinterface

// File: rtl/m_wb_arbiter.sv
// rtl/m_wb_arbiter.sv - register-file writeback arbiter, channel A priority, channel B FIFO
module m_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input logic           w_clk,
    input logic           w_rst,
    m_wb_arbiter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    fifo_wa [DEPTH];
    logic [31:0]   fifo_wd [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;
    logic          a_req;
    logic          push;
    logic          pop;

    // A write to x0 is never a real request on either channel; A always wins the port.
    always_comb begin
        bus.w_b_ready = (count < CW'(DEPTH));
        a_req         = bus.w_a_valid && (bus.w_a_wa != 5'd0);
        push          = bus.w_b_valid && bus.w_b_ready && (bus.w_b_wa != 5'd0);
        pop           = !a_req && (count != '0);
    end

    // FIFO storage; contents need no reset because count gates every use.
    always_ff @(posedge w_clk) begin
        if (push) begin
            fifo_wa[wr_ptr] <= bus.w_b_wa;
            fifo_wd[wr_ptr] <= bus.w_b_wd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Registered write port; address/data hold when idle.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            bus.w_we <= 1'b0;
            bus.w_wa <= '0;
            bus.w_wd <= '0;
        end else if (a_req) begin
            bus.w_we <= 1'b1;
            bus.w_wa <= bus.w_a_wa;
            bus.w_wd <= bus.w_a_wd;
        end else if (pop) begin
            bus.w_we <= 1'b1;
            bus.w_wa <= fifo_wa[rd_ptr];
            bus.w_wd <= fifo_wd[rd_ptr];
        end else begin
            bus.w_we <= 1'b0;
        end
    end

    // Starvation tracking: counts head wait cycles, stall follows the saturated count a cycle later.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            starve_cnt      <= '0;
            bus.w_stall_req <= 1'b0;
        end else begin
            bus.w_stall_req <= (starve_cnt == SW'(STARVE_MAX));
            if ((count == '0) || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    // Pending-write mask over live FIFO slots plus the output register.
    always_comb begin
        bus.w_pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] off;
            off = AW'(i) - rd_ptr;
            if (CW'(off) < count) begin
                bus.w_pend_mask[fifo_wa[i]] = 1'b1;
            end
        end
        if (bus.w_we) begin
            bus.w_pend_mask[bus.w_wa] = 1'b1;
        end
        bus.w_pend_mask[0] = 1'b0;
    end
endmodule
